multi_sprite_address_gen: RTL

//  Pipelined, parametrised sprite address generator for the VGA path. Tracks N_SPRITES

---
 rtl/multi_sprite_address_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_sprite_address_gen.sv
// Two-stage sprite address generator: per-sprite coverage/offset, then priority select.
// Sprite configuration is double-buffered and committed on frame_start.
module multi_sprite_address_gen #(
   parameter  int unsigned N_SPRITES  = 4,
   parameter  int unsigned SPR_W_LOG2 = 6,
   parameter  int unsigned SPR_H_LOG2 = 6,
   parameter  int unsigned COORD_W    = 10,
   localparam int unsigned ID_W       = $clog2(N_SPRITES),
   localparam int unsigned ADDR_W     = ID_W + SPR_H_LOG2 + SPR_W_LOG2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COORD_W-1:0]   pixelx,
   input  logic [COORD_W-1:0]   pixely,
   input  logic                 pixel_valid,
   input  logic                 frame_start,
   input  logic                 cfg_we,
   input  logic [ID_W-1:0]      cfg_sel,
   input  logic [COORD_W-1:0]   cfg_posx,
   input  logic [COORD_W-1:0]   cfg_posy,
   input  logic                 cfg_en,
   input  logic                 cfg_flipx,
   input  logic                 cfg_flipy,
   output logic [ADDR_W-1:0]    address,
   output logic                 hit,
   output logic [ID_W-1:0]      sprite_id,
   output logic [N_SPRITES-1:0] hit_mask,
   output logic                 out_valid
);

   localparam int unsigned XW = COORD_W + 1;
   localparam logic [XW-1:0] SPR_W_LIM = XW'(2 ** SPR_W_LOG2);
   localparam logic [XW-1:0] SPR_H_LIM = XW'(2 ** SPR_H_LOG2);

   typedef struct packed {
      logic [COORD_W-1:0] posx;
      logic [COORD_W-1:0] posy;
      logic               en;
      logic               flipx;
      logic               flipy;
   } sprite_cfg_t;

   sprite_cfg_t pend_q [N_SPRITES];
   sprite_cfg_t act_q  [N_SPRITES];
   sprite_cfg_t pend_d [N_SPRITES];
   sprite_cfg_t wr_cfg;

   // Pending write is visible to the commit in the same cycle (write-through).
   always_comb begin
      wr_cfg = '{posx: cfg_posx, posy: cfg_posy, en: cfg_en,
                 flipx: cfg_flipx, flipy: cfg_flipy};
      for (int i = 0; i < int'(N_SPRITES); i++) begin
         pend_d[i] = pend_q[i];
         if (cfg_we && (cfg_sel == ID_W'(i))) pend_d[i] = wr_cfg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_SPRITES); i++) begin
            pend_q[i] <= '0;
            act_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_SPRITES); i++) begin
            pend_q[i] <= pend_d[i];
            if (frame_start) act_q[i] <= pend_d[i];
         end
      end
   end

   // Stage 1: unsigned offsets at COORD_W+1 bits so right/bottom edges clip.
   logic [XW-1:0]         dx_c [N_SPRITES];
   logic [XW-1:0]         dy_c [N_SPRITES];
   logic [N_SPRITES-1:0]  cover_c;
   logic [SPR_W_LOG2-1:0] col_c [N_SPRITES];
   logic [SPR_H_LOG2-1:0] row_c [N_SPRITES];

   always_comb begin
      for (int i = 0; i < int'(N_SPRITES); i++) begin
         dx_c[i]    = XW'(pixelx) - XW'(act_q[i].posx);
         dy_c[i]    = XW'(pixely) - XW'(act_q[i].posy);
         cover_c[i] = pixel_valid & act_q[i].en &
                      (pixelx >= act_q[i].posx) & (pixely >= act_q[i].posy) &
                      (dx_c[i] < SPR_W_LIM) & (dy_c[i] < SPR_H_LIM);
         col_c[i]   = act_q[i].flipx ? ~dx_c[i][SPR_W_LOG2-1:0] : dx_c[i][SPR_W_LOG2-1:0];
         row_c[i]   = act_q[i].flipy ? ~dy_c[i][SPR_H_LOG2-1:0] : dy_c[i][SPR_H_LOG2-1:0];
      end
   end

   logic [N_SPRITES-1:0]  s1_cover;
   logic [SPR_W_LOG2-1:0] s1_col [N_SPRITES];
   logic [SPR_H_LOG2-1:0] s1_row [N_SPRITES];
   logic                  s1_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_cover <= '0;
         s1_valid <= 1'b0;
         for (int i = 0; i < int'(N_SPRITES); i++) begin
            s1_col[i] <= '0;
            s1_row[i] <= '0;
         end
      end else begin
         s1_cover <= cover_c;
         s1_valid <= pixel_valid;
         for (int i = 0; i < int'(N_SPRITES); i++) begin
            s1_col[i] <= col_c[i];
            s1_row[i] <= row_c[i];
         end
      end
   end

   // Stage 2: lowest covering index wins.
   logic                  hit_c;
   logic [ID_W-1:0]       win_c;
   logic [SPR_W_LOG2-1:0] win_col_c;
   logic [SPR_H_LOG2-1:0] win_row_c;
   logic [ADDR_W-1:0]     addr_c;

   always_comb begin
      hit_c     = |s1_cover;
      win_c     = '0;
      win_col_c = '0;
      win_row_c = '0;
      for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
         if (s1_cover[i]) begin
            win_c     = ID_W'(i);
            win_col_c = s1_col[i];
            win_row_c = s1_row[i];
         end
      end
      addr_c = hit_c ? {win_c, win_row_c, win_col_c} : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address   <= '0;
         hit       <= 1'b0;
         sprite_id <= '0;
         hit_mask  <= '0;
         out_valid <= 1'b0;
      end else begin
         address   <= addr_c;
         hit       <= hit_c;
         sprite_id <= win_c;
         hit_mask  <= s1_cover;
         out_valid <= s1_valid;
      end
   end

endmodule
